// File: rtl/jpeg_pkg.sv
// +--------------------------------------------------------------------------+
// | jpeg_pkg : shared types for the JPEG encoder DCT path                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package jpeg_pkg;

  localparam int DCT_DATA_W  = 8;
  localparam int BLOCK_BEATS = 64;
  localparam int MAX_COMP    = 3;

  typedef struct packed {
    logic                  valid;
    logic [DCT_DATA_W-1:0] data;
  } dctPort_t;

  typedef logic [$clog2(MAX_COMP)-1:0] comp_id_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dct_block_arbiter_tag_fifo.sv
// +--------------------------------------------------------------------------+
// | dct_tag_fifo : synchronous FIFO of component ids for blocks in the core  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dct_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push needs when full.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dct_block_arbiter.sv
// +--------------------------------------------------------------------------+
// | dct_block_arbiter : shares one 8x8 DCT core between NUM_REQ requesters,  |
// | granting whole blocks and tagging core output with the component id.    |
// | DCT_ARB_PRIO_EN selects fixed priority (lowest index) over round-robin.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dct_block_arbiter
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 3,
  parameter int BLOCK_BEATS = jpeg_pkg::BLOCK_BEATS,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output dctPort_t                        dct_in_o,
  input  dctPort_t                        dct_out_i,
  output logic                            out_valid_o,
  output logic [DCT_DATA_W-1:0]           out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]      out_comp_o,
  output logic                            out_sob_o,
  output logic                            out_eob_o,
  output logic                            busy_o,
  output logic                            err_orphan_o
);

  localparam int CW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BLOCK_BEATS);

  arb_state_e      state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]   gnt_q, gnt_d;
  dctPort_t        dct_in_q, dct_in_d;
  logic [BW-1:0]   out_cnt_q, out_cnt_d;
  logic            err_q;

  logic [CW-1:0]   grant_idx;
  logic            grant_found;
  logic            hs;
  logic            tag_push;
  logic            tag_pop;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_head;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_data_arr[r] = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef DCT_ARB_PRIO_EN
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[CW'(i)]) begin
        grant_idx   = CW'(i);
        grant_found = 1'b1;
      end
    end
  end
`else
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] rr_idx;

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    rr_idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = CW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[rr_idx]) begin
        grant_idx   = rr_idx;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (tag_push) begin
      rr_ptr_d = (grant_idx == CW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gnt_d       = gnt_q;
    tag_push    = 1'b0;
    hs          = 1'b0;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && !tag_full) begin
          tag_push = 1'b1;
          gnt_d    = grant_idx;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        req_ready_o[gnt_q] = 1'b1;
        hs                 = req_valid_i[gnt_q];
        if (hs) begin
          if (beat_cnt_q == BW'(BLOCK_BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dct_in_d       = '0;
    dct_in_d.valid = hs;
    if (hs) dct_in_d.data = DCT_DATA_W'(req_data_arr[gnt_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      dct_in_q   <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      dct_in_q   <= dct_in_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_q | (dct_out_i.valid && tag_empty);
    end
  end

  dct_tag_fifo #(
    .WIDTH (CW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .data_i  (grant_idx),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // Output beats are only counted against a known block; orphans leave out_cnt alone.
  assign out_valid_o  = dct_out_i.valid;
  assign out_data_o   = dct_out_i.data;
  assign out_comp_o   = tag_empty ? '0 : tag_head;
  assign out_sob_o    = dct_out_i.valid && !tag_empty && (out_cnt_q == '0);
  assign out_eob_o    = dct_out_i.valid && !tag_empty && (out_cnt_q == BW'(BLOCK_BEATS - 1));
  assign tag_pop      = out_eob_o;
  assign out_cnt_d    = out_eob_o ? '0 :
                        (dct_out_i.valid && !tag_empty) ? out_cnt_q + 1'b1 : out_cnt_q;
  assign dct_in_o     = dct_in_q;
  assign busy_o       = (state_q != IDLE) || !tag_empty;
  assign err_orphan_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dct_block_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_dct_block_arbiter : directed self-checking bench with a stub DCT core |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dct_block_arbiter;
  import jpeg_pkg::*;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int BB = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  dctPort_t       dct_in;
  dctPort_t       dct_out;
  logic           out_valid;
  logic [7:0]     out_data;
  logic [1:0]     out_comp;
  logic           out_sob, out_eob, busy, err_orphan;

  always #5 clk = ~clk;

  dct_block_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .dct_in_o     (dct_in),
    .dct_out_i    (dct_out),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_comp_o   (out_comp),
    .out_sob_o    (out_sob),
    .out_eob_o    (out_eob),
    .busy_o       (busy),
    .err_orphan_o (err_orphan)
  );

  int checks = 0;
  int errors = 0;

  // requester sources and stub core
  int       rem [NR];
  int       cnt [NR];
  bit       drop [NR];
  int       cyc = 0;
  int       lat = 2;
  dctPort_t pipe [256];
  bit       manual = 1'b0;
  dctPort_t man_val;

  // monitor state
  int n_in, first_in_cyc, last_in_cyc, hs_first_cyc, blk_end_cyc, in_data_bad;
  int glog[$], gcyc[$], taglog[$], eob_cyc[$];
  int n_out, n_eob, sob_bad, comp_bad, out_data_bad, onehot_bad, max_out, stall1, cur_g;
  logic [NR-1:0] prev_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int g, input int j);
    return 8'((j % 8) + 16 * g);
  endfunction

  task automatic drive_req();
    for (int r = 0; r < NR; r++) begin
      req_valid[r] = (rem[r] > 0) && !(drop[r] && (cyc % 4 == 3));
      req_data[r*DW +: DW] = exp_data(r, cnt[r] % BB);
    end
  endtask

  task automatic clear_mon();
    n_in = 0; first_in_cyc = -1; last_in_cyc = -1; hs_first_cyc = -1; blk_end_cyc = -1;
    in_data_bad = 0; n_out = 0; n_eob = 0; sob_bad = 0; comp_bad = 0; out_data_bad = 0;
    onehot_bad = 0; max_out = 0; stall1 = 0; cur_g = 0; prev_ready = '0;
    glog.delete(); gcyc.delete(); taglog.delete(); eob_cyc.delete();
  endtask

  // Observe at the falling edge, then advance one rising edge and update stimulus.
  task automatic tick();
    logic [NR-1:0] hs;
    dctPort_t      pre;
    int            blk, idx;
    @(negedge clk);
    hs  = req_valid & req_ready;
    pre = dct_in;
    if ($countones(req_ready) > 1) onehot_bad++;
    if (req_ready != '0 && prev_ready == '0) begin
      for (int r = 0; r < NR; r++) begin
        if (req_ready[r]) begin
          glog.push_back(r); gcyc.push_back(cyc); cur_g = r;
        end
      end
    end
    prev_ready = req_ready;
    if (hs != '0 && hs_first_cyc < 0) hs_first_cyc = cyc;
    if (hs_first_cyc >= 0 && req_ready[1] && !req_valid[1]) stall1++;
    if (dct_in.valid) begin
      if (first_in_cyc < 0) first_in_cyc = cyc;
      last_in_cyc = cyc;
      if (dct_in.data !== exp_data(cur_g, n_in % BB)) in_data_bad++;
      n_in++;
      if (n_in == BB) blk_end_cyc = cyc;
    end
    if (out_valid) begin
      blk = n_out / BB;
      idx = n_out % BB;
      if (out_sob !== (idx == 0) || out_eob !== (idx == BB - 1)) sob_bad++;
      if (out_sob) taglog.push_back(int'(out_comp));
      if (blk < glog.size()) begin
        if (int'(out_comp) != glog[blk]) comp_bad++;
        if (out_data !== exp_data(glog[blk], idx)) out_data_bad++;
      end
      if (out_eob) begin n_eob++; eob_cyc.push_back(cyc); end
      n_out++;
    end
    if (glog.size() - n_eob > max_out) max_out = glog.size() - n_eob;
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < NR; r++) if (hs[r]) begin cnt[r]++; rem[r]--; end
    for (int i = 255; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = pre;
    if (rst) for (int i = 0; i < 256; i++) pipe[i] = '0;
    dct_out = manual ? man_val : pipe[lat-1];
    drive_req();
  endtask

  task automatic clear_src();
    for (int r = 0; r < NR; r++) begin rem[r] = 0; cnt[r] = 0; drop[r] = 1'b0; end
    manual = 1'b0; man_val = '0;
    drive_req();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic run_until_eob(input int n, input int budget, input string tag);
    int k = 0;
    while (n_eob < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(n_eob >= n), 1);
  endtask

  initial begin
    int k;
    logic [31:0] pack;
    rst = 1'b1;
    dct_out = '0;
    for (int i = 0; i < 256; i++) pipe[i] = '0;
    clear_src();
    clear_mon();

    // Reset state
    do_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_dct_in", 32'(dct_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_orphan", 32'(err_orphan), 0);
    chk("rst_out_valid", 32'(out_valid), 0);

    // 1: requester 0 alone, one continuous block
    lat = 2;
    rem[0] = 64; drive_req();
    run_until_eob(1, 300, "t1_done");
    #1;
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_n_in", 32'(n_in), 64);
    chk("t1_in_latency", 32'(first_in_cyc - hs_first_cyc), 1);
    chk("t1_in_contig", 32'(last_in_cyc - first_in_cyc), 63);
    chk("t1_in_data", 32'(in_data_bad), 0);
    chk("t1_n_out", 32'(n_out), 64);
    chk("t1_comp", 32'(comp_bad), 0);
    chk("t1_sob_eob", 32'(sob_bad), 0);
    chk("t1_out_data", 32'(out_data_bad), 0);
    chk("t1_grant", 32'(glog.size() == 1 && glog[0] == 0), 1);
    chk("t1_err", 32'(err_orphan), 0);

    // 2: all requesters valid, six blocks
    do_reset();
    for (int r = 0; r < NR; r++) rem[r] = 128;
    drive_req();
    run_until_eob(6, 1000, "t2_done");
    chk("t2_ngrant", 32'(glog.size()), 6);
    pack = '0;
    for (int i = 0; i < glog.size() && i < 6; i++) pack = (pack << 4) | 32'(glog[i]);
`ifdef DCT_ARB_PRIO_EN
    chk("t2_order", pack, 32'h001122);
`else
    chk("t2_order", pack, 32'h012012);
`endif
    k = 0;
    for (int i = 1; i < gcyc.size(); i++) if (gcyc[i] - gcyc[i-1] != 65) k++;
    chk("t2_gap", 32'(k), 0);
    chk("t2_n_in", 32'(n_in), 384);
    chk("t2_in_data", 32'(in_data_bad), 0);
    chk("t2_comp", 32'(comp_bad), 0);
    chk("t2_sob_eob", 32'(sob_bad), 0);

    // 3: requester 1 with bubbles, others arrive mid-block
    do_reset();
    rem[1] = 64; drop[1] = 1'b1; drive_req();
    for (int i = 0; i < 10; i++) tick();
    rem[0] = 64; rem[2] = 64; drive_req();
    run_until_eob(3, 1500, "t3_done");
    chk("t3_first_grant", 32'(glog.size() >= 2 && glog[0] == 1), 1);
`ifdef DCT_ARB_PRIO_EN
    chk("t3_second_grant", 32'(glog[1]), 0);
`else
    chk("t3_second_grant", 32'(glog[1]), 2);
`endif
    chk("t3_stalls_seen", 32'(stall1 >= 15), 1);
    chk("t3_span", 32'(blk_end_cyc - first_in_cyc + 1), 32'(64 + stall1));
    chk("t3_next_after_done", 32'(gcyc[1] - blk_end_cyc), 1);
    chk("t3_onehot", 32'(onehot_bad), 0);
    chk("t3_in_data", 32'(in_data_bad), 0);

    // 4: long-latency core, five blocks, at most four outstanding
    lat = 200;
    do_reset();
    rem[0] = 128; rem[1] = 128; rem[2] = 64; drive_req();
    run_until_eob(5, 2000, "t4_done");
    chk("t4_ngrant", 32'(glog.size()), 5);
    pack = '0;
    for (int i = 0; i < glog.size() && i < 5; i++) pack = (pack << 4) | 32'(glog[i]);
`ifdef DCT_ARB_PRIO_EN
    chk("t4_order", pack, 32'h00112);
`else
    chk("t4_order", pack, 32'h01201);
`endif
    chk("t4_fifth_after_pop", 32'(gcyc[4] - eob_cyc[0]), 2);
    chk("t4_max_outstanding", 32'(max_out), 4);
    chk("t4_comp", 32'(comp_bad), 0);
    lat = 2;

    // 5: reset at beat 30, restart from a clean arbiter
    do_reset();
    rem[1] = 64; drive_req();
    k = 0;
    while (cnt[1] < 30 && k < 200) begin tick(); k++; end
    chk("t5_reach30", 32'(cnt[1]), 30);
    rst = 1'b1;
    clear_src();
    tick();
    #1;
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_dct_in", 32'(dct_in), 0);
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    clear_mon();
    rem[1] = 64; rem[2] = 64; drive_req();
    run_until_eob(1, 400, "t5_done");
    chk("t5_first_grant", 32'(glog[0]), 1);
    chk("t5_first_tag", 32'(taglog.size() >= 1 && taglog[0] == 1), 1);
    chk("t5_in_data", 32'(in_data_bad), 0);
    chk("t5_sob_eob", 32'(sob_bad), 0);

    // 6: orphan output beat
    do_reset();
    manual = 1'b1;
    man_val.valid = 1'b1;
    man_val.data  = 8'h55;
    tick();
    #1;
    chk("t6_out_valid", 32'(out_valid), 1);
    chk("t6_out_comp", 32'(out_comp), 0);
    chk("t6_no_sob", 32'(out_sob), 0);
    man_val = '0;
    tick();
    #1;
    chk("t6_err_set", 32'(err_orphan), 1);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t6_err_sticky", 32'(err_orphan), 1);
    chk("t6_busy", 32'(busy), 0);
    do_reset();
    #1;
    chk("t6_err_cleared", 32'(err_orphan), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
